// File: rtl/arith_ctrl_pkg.sv
// Shared types and helpers for the arithmetic sequencing controllers.
package arith_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Iteration counter width: enough to hold N plus one spare bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return 32'($clog2(n)) + 32'd1;
    endfunction

endpackage

// File: rtl/n_bit_subtractor.sv
// Combinational ripple-borrow subtractor: diff_c = a - b - borin when enabled.
module n_bit_subtractor #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         borin,
    input  logic         enable,
    output logic [W-1:0] diff_c,
    output logic         borout_c
);

    logic [W:0]   bchain;
    logic [W-1:0] diff_raw;

    // Bit-serial borrow ripple, LSB first.
    always_comb begin
        bchain    = '0;
        diff_raw  = '0;
        bchain[0] = borin;
        for (int i = 0; i < int'(W); i++) begin
            diff_raw[i]  = a[i] ^ b[i] ^ bchain[i];
            bchain[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bchain[i]);
        end
    end

    assign diff_c   = enable ? diff_raw : '0;
    assign borout_c = enable & bchain[W];

endmodule

// File: rtl/restoring_divider_ctrl.sv
// Sequential unsigned restoring divider: one quotient bit per RUN cycle
// through a single shared subtractor, with a start/done handshake.
module restoring_divider_ctrl
    import arith_ctrl_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = cnt_w(N);
    localparam int unsigned RW = N + 1;

    state_t        state, next_state;
    logic [N-1:0]  q_q, q_d;
    logic [RW-1:0] r_q, r_d;
    logic [N-1:0]  d_q, d_d;
    logic          z_q, z_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          ready_d, busy_d, done_d, dz_d;
    logic [N-1:0]  quotient_d, remainder_d;

    logic [RW-1:0] trial, diff;
    logic          borout;
    logic          unused_r_msb;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign trial        = {r_q[N-1:0], q_q[N-1]};
    assign unused_r_msb = r_q[N];

    n_bit_subtractor #(
        .W (RW)
    ) u_sub (
        .a        (trial),
        .b        ({1'b0, d_q}),
        .borin    (1'b0),
        .enable   (1'b1),
        .diff_c   (diff),
        .borout_c (borout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, datapath and output-register update logic.
    always_comb begin
        next_state  = state;
        q_d         = q_q;
        r_d         = r_q;
        d_d         = d_q;
        z_d         = z_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient;
        remainder_d = remainder;
        dz_d        = div_by_zero;

        case (state)
            IDLE: begin
                if (start) begin
                    q_d        = dividend;
                    d_d        = divisor;
                    r_d        = '0;
                    z_d        = (divisor == '0);
                    next_state = (divisor == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                cnt_d      = '0;
                next_state = RUN;
            end
            RUN: begin
                r_d   = borout ? trial : diff;
                q_d   = {q_q[N-2:0], ~borout};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                // Zero divisor reports all-ones quotient and the untouched dividend.
                quotient_d  = z_q ? '1 : q_q;
                remainder_d = z_q ? q_q : r_q[N-1:0];
                dz_d        = z_q;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase

        ready_d = (next_state == IDLE);
        busy_d  = (next_state == LOAD) || (next_state == RUN);
        done_d  = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            z_q         <= 1'b0;
            cnt_q       <= '0;
            ready       <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            q_q         <= q_d;
            r_q         <= r_d;
            d_q         <= d_d;
            z_q         <= z_d;
            cnt_q       <= cnt_d;
            ready       <= ready_d;
            busy        <= busy_d;
            done        <= done_d;
            quotient    <= quotient_d;
            remainder   <= remainder_d;
            div_by_zero <= dz_d;
        end
    end

endmodule

// File: tb/tb_restoring_divider_ctrl.sv
// Self-checking bench for restoring_divider_ctrl: vector table, corner
// sequences and a randomized sweep against plain integer division.
module tb_restoring_divider_ctrl;

    localparam int unsigned N        = 8;
    localparam int          LAT_NORM = N + 2;
    localparam int          BUSY_NORM = N + 1;
    localparam int          N_RAND   = 2000;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    restoring_divider_ctrl #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        int           lat;
        int           busy_n;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge: present operands for one edge, then scramble them.
    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = N'($urandom);
        divisor  = N'($urandom);
    endtask

    // Counts edges since the accepting edge until done is seen.
    task automatic wait_done(input bit hold_chk, input logic [N-1:0] hold_q,
                             output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        while (!done && lat < 4 * int'(N) + 10) begin
            if (busy) busy_n++;
            if (hold_chk && lat == 3) check("hold_quotient", 32'(quotient), 32'(hold_q));
            @(negedge clk);
            lat++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                           output int lat, output int busy_n);
        @(negedge clk);
        launch(a, b);
        wait_done(1'b0, '0, lat, busy_n);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   lat, bn;
        logic [N-1:0] a, b;

        vecs[0] = '{a: 8'd100, b: 8'd7,  q: 8'd14,  r: 8'd2,  dz: 1'b0, lat: LAT_NORM, busy_n: BUSY_NORM};
        vecs[1] = '{a: 8'd255, b: 8'd1,  q: 8'd255, r: 8'd0,  dz: 1'b0, lat: LAT_NORM, busy_n: BUSY_NORM};
        vecs[2] = '{a: 8'd5,   b: 8'd9,  q: 8'd0,   r: 8'd5,  dz: 1'b0, lat: LAT_NORM, busy_n: BUSY_NORM};
        vecs[3] = '{a: 8'd37,  b: 8'd0,  q: 8'hFF,  r: 8'd37, dz: 1'b1, lat: 1,        busy_n: 0};
        vecs[4] = '{a: 8'd0,   b: 8'd5,  q: 8'd0,   r: 8'd0,  dz: 1'b0, lat: LAT_NORM, busy_n: BUSY_NORM};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(ready), 32'd1);
        check("idle_done", 32'(done), 32'd0);
        check("idle_quotient", 32'(quotient), 32'd0);
        check("idle_remainder", 32'(remainder), 32'd0);
        check("idle_dz", 32'(div_by_zero), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_div(vecs[i].a, vecs[i].b, lat, bn);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bn), 32'(vecs[i].busy_n));
            check($sformatf("vec%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
            check($sformatf("vec%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
            check($sformatf("vec%0d_dz", i), 32'(div_by_zero), 32'(vecs[i].dz));
            check($sformatf("vec%0d_ready_at_done", i), 32'(ready), 32'd1);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
        end

        // Start during RUN is dropped; back-to-back start right at done is taken.
        @(negedge clk);
        launch(8'd200, 8'd13);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0, '0, lat, bn);
        check("ignore_latency", 32'(lat + 4), 32'(LAT_NORM));
        check("ignore_quotient", 32'(quotient), 32'd15);
        check("ignore_remainder", 32'(remainder), 32'd5);
        launch(8'd9, 8'd3);
        wait_done(1'b1, 8'd15, lat, bn);
        check("b2b_latency", 32'(lat), 32'(LAT_NORM));
        check("b2b_quotient", 32'(quotient), 32'd3);
        check("b2b_remainder", 32'(remainder), 32'd0);

        // Asynchronous reset in the 4th RUN cycle aborts without a done pulse.
        @(negedge clk);
        launch(8'd250, 8'd6);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bn = 0;
        for (int c = 0; c < int'(N) + 4; c++) begin
            @(negedge clk);
            if (done) bn++;
        end
        check("abort_no_done", 32'(bn), 32'd0);
        run_div(8'd250, 8'd6, lat, bn);
        check("fresh_latency", 32'(lat), 32'(LAT_NORM));
        check("fresh_quotient", 32'(quotient), 32'd41);
        check("fresh_remainder", 32'(remainder), 32'd4);

        for (int i = 0; i < N_RAND; i++) begin
            a = N'($urandom);
            b = N'($urandom_range(1, (1 << N) - 1));
            run_div(a, b, lat, bn);
            check($sformatf("rand%0d_%0d/%0d_latency", i, a, b), 32'(lat), 32'(LAT_NORM));
            check($sformatf("rand%0d_%0d/%0d_quotient", i, a, b), 32'(quotient), 32'(a / b));
            check($sformatf("rand%0d_%0d/%0d_remainder", i, a, b), 32'(remainder), 32'(a % b));
            check($sformatf("rand%0d_dz", i), 32'(div_by_zero), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
